// File: rtl/sfr_arb_pkg.sv
// Shared types and helpers for the SFR access arbiter.
// Build option: SFR_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
package sfr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int MAX_REQ = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfr_rr_select.sv
// Winner select for the SFR arbiter: round-robin by default,
// fixed lowest-index priority under SFR_ARB_FIXED_PRIO_EN.
module sfr_rr_select
  import sfr_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic [IW-1:0] idx_d;
  logic          any_d;

`ifdef SFR_ARB_FIXED_PRIO_EN

  logic unused_adv;
  assign unused_adv = adv_i ^ clk ^ reset;

  always_comb begin
    any_d = 1'b0;
    idx_d = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_i[k]) begin
        any_d = 1'b1;
        idx_d = IW'(k);
      end
    end
  end

`else

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] cand;
  int            j;

  // Scan upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    any_d = 1'b0;
    idx_d = '0;
    cand  = '0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IW'(j);
      if (!any_d && valid_i[cand]) begin
        any_d = 1'b1;
        idx_d = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (idx_d == IW'(NUM_REQ - 1)) ? '0 : idx_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

`endif

  always_comb begin
    gnt_o        = '0;
    gnt_o[idx_d] = any_d;
  end

  assign idx_o = idx_d;
  assign any_o = any_d;

endmodule

// File: rtl/sfr_arbiter.sv
// Multi-master access controller for the SFR register file port.
// Build option: SFR_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
module sfr_arbiter
  import sfr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [ADDR_WIDTH-1:0]         sfr_address,
  output logic [DATA_WIDTH-1:0]         sfr_write_data,
  output logic                          sfr_we,
  output logic                          sfr_re,
  input  logic [DATA_WIDTH-1:0]         sfr_read_data,
  output logic                          busy
);

  localparam int IW = idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_cfg
    $error("sfr_arbiter: NUM_REQ out of range");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [IW-1:0]         gidx_q, gidx_d;
  logic [NUM_REQ-1:0]    rsp_q, rsp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;

  logic [NUM_REQ-1:0]    sel_gnt;
  logic [IW-1:0]         sel_idx;
  logic                  sel_any;
  logic                  hs;

  sfr_rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_sel (
    .clk     (clk),
    .reset   (reset),
    .valid_i (req_valid),
    .adv_i   (hs),
    .gnt_o   (sel_gnt),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  // SFR drive is loaded at accept and cleared once ACCESS closes.
  always_comb begin
    state_d = state_q;
    addr_d  = '0;
    wdata_d = '0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    gidx_d  = gidx_q;
    rsp_d   = '0;
    rdata_d = '0;
    hs      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          hs      = 1'b1;
          state_d = ACCESS;
          addr_d  = req_addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
          we_d    = req_we[sel_idx];
          re_d    = ~req_we[sel_idx];
          gidx_d  = sel_idx;
        end
      end
      ACCESS: begin
        state_d       = RESP;
        rsp_d[gidx_q] = 1'b1;
        rdata_d       = we_q ? '0 : sfr_read_data;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      gidx_q  <= '0;
      rsp_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      gidx_q  <= gidx_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready = (state_q == IDLE)
                   ? (sel_gnt & {NUM_REQ{reset}})
                   : '0;

  assign sfr_address    = addr_q;
  assign sfr_write_data = wdata_q;
  assign sfr_we         = we_q;
  assign sfr_re         = re_q;
  assign rsp_valid      = rsp_q;
  assign rsp_rdata      = rdata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_sfr_arbiter.sv
// Directed self-checking bench for sfr_arbiter (NUM_REQ=4).
// Covers both builds via SFR_ARB_FIXED_PRIO_EN.
module tb_sfr_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 8;

`ifdef SFR_ARB_FIXED_PRIO_EN
  localparam logic [31:0] SEQ_CONT = 32'h0000_0000;
  localparam logic [31:0] SEQ_WRAP = 32'h0000_0011;
`else
  localparam logic [31:0] SEQ_CONT = 32'h0000_1010;
  localparam logic [31:0] SEQ_WRAP = 32'h0000_0031;
`endif

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic [AW-1:0]    sfr_address;
  logic [DW-1:0]    sfr_write_data;
  logic             sfr_we;
  logic             sfr_re;
  logic [DW-1:0]    sfr_read_data;
  logic             busy;

  logic [DW-1:0] mem [256];
  int n_cmp;
  int n_err;
  int cyc;
  int strb_cnt;
  int rsp_cnt;

  sfr_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .sfr_address    (sfr_address),
    .sfr_write_data (sfr_write_data),
    .sfr_we         (sfr_we),
    .sfr_re         (sfr_re),
    .sfr_read_data  (sfr_read_data),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in: sync write, combinational read.
  always @(posedge clk) if (sfr_we) mem[sfr_address] <= sfr_write_data;
  assign sfr_read_data = mem[sfr_address];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sfr_we || sfr_re) strb_cnt <= strb_cnt + 1;
    if (rsp_valid != '0) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic set_req(input int r, input logic we,
                         input logic [7:0] a, input logic [7:0] d);
    req_we[r]          = we;
    req_addr[r*AW+:AW] = a;
    req_wdata[r*DW+:DW] = d;
  endtask

  task automatic do_op(input int r, input logic we, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] exp_rd);
    set_req(r, we, a, d);
    req_valid = NR'(1 << r);
    wait_ready();
    check("op_rdy", req_ready, 32'(1) << r);
    check("op_busy_idle", busy, 0);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("op_we", sfr_we, we);
    check("op_re", sfr_re, !we);
    check("op_addr", sfr_address, a);
    check("op_wdata", sfr_write_data, d);
    check("op_busy_acc", busy, 1);
    @(negedge clk);
    check("op_rsp", rsp_valid, 32'(1) << r);
    check("op_rdata", rsp_rdata, exp_rd);
    check("op_we_off", sfr_we, 0);
    check("op_busy_rsp", busy, 1);
  endtask

  task automatic contend(input logic [NR-1:0] mask, input int n,
                         input logic [31:0] seq, input logic [31:0] exp_rd);
    int g;
    int last;
    last = 0;
    req_valid = mask;
    for (int k = 0; k < n; k++) begin
      g = int'(seq[k*4 +: 4]);
      wait_ready();
      check("rr_gnt", req_ready, 32'(1) << g);
      check("rr_busy_idle", busy, 0);
      if (k > 0) check("rr_gap", cyc - last, 3);
      last = cyc;
      @(negedge clk);
      check("rr_re", sfr_re, 1);
      check("rr_addr", sfr_address, req_addr[g*AW +: AW]);
      check("rr_busy_acc", busy, 1);
      @(negedge clk);
      check("rr_rsp", rsp_valid, 32'(1) << g);
      check("rr_rdata", rsp_rdata, exp_rd[g*8 +: 8]);
      check("rr_busy_rsp", busy, 1);
    end
    req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int r0;
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    strb_cnt = 0;
    rsp_cnt = 0;
    reset = 1'b0;
    req_valid = 4'b0001;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_we", sfr_we, 0);
    check("rst_re", sfr_re, 0);
    check("rst_rsp", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", sfr_address, 0);
    req_valid = '0;
    reset = 1'b1;
    @(negedge clk);

    // Single write then read.
    do_op(0, 1'b1, 8'h10, 8'hA5, 8'h00);
    do_op(0, 1'b0, 8'h10, 8'h00, 8'hA5);
    do_op(1, 1'b1, 8'h11, 8'h5A, 8'h00);

    // Two readers held valid.
    set_req(0, 1'b0, 8'h10, 8'h00);
    set_req(1, 1'b0, 8'h11, 8'h00);
    contend(4'b0011, 4, SEQ_CONT, 32'h0000_5AA5);

    // Grant to 3, then 1 and 3 compete across the wrap.
    do_op(3, 1'b0, 8'h10, 8'h00, 8'hA5);
    set_req(1, 1'b0, 8'h11, 8'h00);
    set_req(3, 1'b0, 8'h10, 8'h00);
    contend(4'b1010, 2, SEQ_WRAP, 32'hA500_5A00);

    // Valid withdrawn while another access is in flight.
    set_req(0, 1'b0, 8'h10, 8'h00);
    req_valid = 4'b0001;
    wait_ready();
    check("wd_rdy0", req_ready, 1);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    set_req(1, 1'b0, 8'h11, 8'h00);
    req_valid = 4'b0010;
    #1 check("wd_rdy_acc", req_ready, 0);
    @(negedge clk);
    check("wd_rsp0", rsp_valid, 1);
    check("wd_rdata0", rsp_rdata, 8'hA5);
    req_valid = '0;
    s0 = strb_cnt;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (req_ready != '0) seen = 1'b1;
    end
    check("wd_no_rdy", seen, 0);
    check("wd_no_strb", strb_cnt - s0, 0);
    check("wd_idle", busy, 0);

    // Reset in the ACCESS cycle of a write.
    do_op(2, 1'b1, 8'h20, 8'h77, 8'h00);
    set_req(2, 1'b1, 8'h20, 8'h3C);
    req_valid = 4'b0100;
    wait_ready();
    check("ra_rdy", req_ready, 4'b0100);
    @(posedge clk);
    #1 req_valid = '0;
    check("ra_we_pre", sfr_we, 1);
    r0 = rsp_cnt;
    #1 reset = 1'b0;
    #1;
    check("ra_we_drop", sfr_we, 0);
    check("ra_busy_drop", busy, 0);
    check("ra_addr_drop", sfr_address, 0);
    check("ra_rsp_drop", rsp_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("ra_no_rsp", rsp_cnt - r0, 0);

    // Pointer back at 0: 1 beats 3.
    set_req(1, 1'b0, 8'h11, 8'h00);
    set_req(3, 1'b0, 8'h10, 8'h00);
    contend(4'b1010, 1, 32'h0000_0001, 32'hA500_5A00);
    do_op(2, 1'b0, 8'h20, 8'h00, 8'h77);

    // Back-to-back reads from one requester.
    set_req(0, 1'b0, 8'h10, 8'h00);
    contend(4'b0001, 8, 32'h0000_0000, 32'h0000_00A5);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
